// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: takes one client request, runs one bus
// access guarded by a timeout, then returns a one-cycle response.
module bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  output logic        rd_bus,
  output logic        wr_bus,
  output logic [3:0]  data_mask_bus,
  input  logic        fc_bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

  // A request is illegal if its size code is reserved or it would spill past the word.
  function automatic logic illegal_req(input logic [1:0] size, input logic [1:0] offset);
    logic [2:0] bytes;
    case (size)
      2'b00:   bytes = 3'd1;
      2'b01:   bytes = 3'd2;
      2'b10:   bytes = 3'd4;
      default: bytes = 3'd0;
    endcase
    return (size == 2'b11) || (({1'b0, offset} + bytes) > 3'd4);
  endfunction

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [31:0] addr_q, addr_q_next;
  logic [31:0] wdata_q, wdata_q_next;
  logic [1:0]  size_q, size_q_next;
  logic        write_q, write_q_next;

  logic        rd_next, wr_next;
  logic [31:0] addr_bus_next;
  logic [3:0]  mask_next;
  logic        resp_valid_next;
  logic [31:0] resp_rdata_next;
  logic        resp_error_next;
  logic        fc_done;

  assign fc_done   = (fc_bus == 1'b1);
  assign req_ready = (state == IDLE) && rst;
  assign data_bus  = wr_bus ? wdata_q : 32'bz;

  // Bus strobes and response fields are computed one cycle ahead and registered.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    addr_q_next     = addr_q;
    wdata_q_next    = wdata_q;
    size_q_next     = size_q;
    write_q_next    = write_q;
    rd_next         = 1'b0;
    wr_next         = 1'b0;
    addr_bus_next   = 32'd0;
    mask_next       = 4'd0;
    resp_valid_next = 1'b0;
    resp_rdata_next = resp_rdata;
    resp_error_next = resp_error;

    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_q_next  = req_addr;
          wdata_q_next = req_wdata;
          size_q_next  = req_size;
          write_q_next = req_write;
          cnt_next     = 16'd0;
          if (illegal_req(req_size, req_addr[1:0])) begin
            state_next      = DONE;
            resp_valid_next = 1'b1;
            resp_error_next = 1'b1;
            resp_rdata_next = 32'd0;
          end else begin
            state_next    = ACCESS;
            rd_next       = !req_write;
            wr_next       = req_write;
            addr_bus_next = req_addr;
            mask_next     = size_mask(req_size);
          end
        end
      end

      ACCESS: begin
        if (fc_done) begin
          state_next      = DONE;
          resp_valid_next = 1'b1;
          resp_error_next = 1'b0;
          resp_rdata_next = write_q ? 32'd0 : (data_bus & lane_bits(size_mask(size_q)));
        end else if (cnt == LAST_WAIT) begin
          state_next      = DONE;
          resp_valid_next = 1'b1;
          resp_error_next = 1'b1;
          resp_rdata_next = 32'd0;
        end else begin
          cnt_next      = cnt + 16'd1;
          rd_next       = !write_q;
          wr_next       = write_q;
          addr_bus_next = addr_q;
          mask_next     = size_mask(size_q);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 16'd0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      size_q        <= 2'd0;
      write_q       <= 1'b0;
      rd_bus        <= 1'b0;
      wr_bus        <= 1'b0;
      addr_bus      <= 32'd0;
      data_mask_bus <= 4'd0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_error    <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      addr_q        <= addr_q_next;
      wdata_q       <= wdata_q_next;
      size_q        <= size_q_next;
      write_q       <= write_q_next;
      rd_bus        <= rd_next;
      wr_bus        <= wr_next;
      addr_bus      <= addr_bus_next;
      data_mask_bus <= mask_next;
      resp_valid    <= resp_valid_next;
      resp_rdata    <= resp_rdata_next;
      resp_error    <= resp_error_next;
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: a wait-programmable responder, a transaction-timeline
// reference model checked every cycle, directed scenarios and a random phase.
module tb_bus_initiator;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_error, rd_bus, wr_bus;
  logic [31:0] resp_rdata, addr_bus;
  logic [3:0]  data_mask_bus;
  wire  [31:0] data_bus;
  wire         fc_bus;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Responder: completes reads after txn_wait strobe cycles (combinational fc),
  // writes one cycle later (registered fc); absent means it never answers.
  int unsigned nxt_wait = 0;
  logic        nxt_absent = 1'b0;
  logic [31:0] nxt_word = 32'd0;
  int unsigned txn_wait = 0;
  logic        txn_absent = 1'b0;
  logic [31:0] txn_word = 32'd0;
  int unsigned busy = 0;
  logic [31:0] resp_reg = 32'd0;
  logic        fc_val;

  assign fc_val   = !txn_absent && ((rd_bus && busy >= txn_wait) || (wr_bus && busy >= txn_wait + 1));
  assign fc_bus   = txn_absent ? 1'bz : fc_val;
  assign data_bus = (rd_bus && !txn_absent) ? txn_word : 32'bz;

  always @(posedge clk) begin
    if (rst && req_valid && req_ready) begin
      txn_wait   <= nxt_wait;
      txn_absent <= nxt_absent;
      txn_word   <= nxt_word;
    end
    busy <= (rd_bus || wr_bus) ? busy + 1 : 0;
    if (rst && wr_bus && fc_val) resp_reg <= data_bus;
  end

  bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .addr_bus(addr_bus), .data_bus(data_bus), .rd_bus(rd_bus), .wr_bus(wr_bus),
    .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, expected);
    end
  endtask

  // Reference model: each accepted request becomes a timeline
  // (bus window, response cycle, next free cycle) derived from the responder wait.
  bit          model_ok = 0;
  int          free_cyc = 0, resp_cyc = -1, acc_cyc = -1, len = 0;
  logic        m_write = 1'b0, m_err = 1'b0, held_err = 1'b0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_rdata = 32'd0, held_rdata = 32'd0, exp_mem = 32'd0;
  logic [3:0]  m_mask = 4'd0;
  logic        p_rst = 1'b1, p_valid = 1'b0, p_write = 1'b0, p_absent = 1'b0, p_ready_exp = 1'b0;
  logic [31:0] p_addr = 32'd0, p_wdata = 32'd0, p_word = 32'd0;
  logic [1:0]  p_size = 2'd0;
  int unsigned p_wait = 0;

  always @(negedge clk) begin : compare
    int   bytes;
    int   fc_at;
    logic ill;
    logic in_acc;
    logic exp_ready;
    exp_ready = 1'b0;
    if (!p_rst) begin
      model_ok = 1; free_cyc = cyc; resp_cyc = -1; acc_cyc = -1; len = 0;
      held_rdata = 32'd0; held_err = 1'b0;
    end else if (model_ok && p_valid && p_ready_exp) begin
      bytes   = (p_size == 2'b00) ? 1 : (p_size == 2'b01) ? 2 : 4;
      ill     = (p_size == 2'b11) || (int'(p_addr[1:0]) + bytes > 4);
      m_write = p_write; m_addr = p_addr; m_wdata = p_wdata;
      m_mask  = (p_size == 2'b00) ? 4'b0001 : (p_size == 2'b01) ? 4'b0011 : 4'b1111;
      acc_cyc = cyc;
      if (ill) begin
        len = 0; m_err = 1'b1; m_rdata = 32'd0;
      end else begin
        fc_at = p_absent ? 1000 : int'(p_wait) + (p_write ? 1 : 0);
        if (fc_at < T) begin
          len = fc_at + 1; m_err = 1'b0;
          m_rdata = p_write ? 32'd0 :
                    p_word & ((p_size == 2'b00) ? 32'h0000_00FF : (p_size == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF);
        end else begin
          len = T; m_err = 1'b1; m_rdata = 32'd0;
        end
      end
      resp_cyc = cyc + len;
      free_cyc = cyc + len + 1;
    end
    if (model_ok) begin
      if (cyc == resp_cyc) begin
        held_rdata = m_rdata; held_err = m_err;
        if (m_write && !m_err) exp_mem = m_wdata;
      end
      in_acc    = (acc_cyc >= 0) && (cyc >= acc_cyc) && (cyc < acc_cyc + len);
      exp_ready = rst && (cyc >= free_cyc);
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("resp_valid", 32'(resp_valid), 32'(cyc == resp_cyc));
      checkOutput("resp_rdata", resp_rdata, held_rdata);
      checkOutput("resp_error", 32'(resp_error), 32'(held_err));
      checkOutput("rd_bus", 32'(rd_bus), 32'(in_acc && !m_write));
      checkOutput("wr_bus", 32'(wr_bus), 32'(in_acc && m_write));
      checkOutput("addr_bus", addr_bus, in_acc ? m_addr : 32'd0);
      checkOutput("data_mask_bus", 32'(data_mask_bus), in_acc ? 32'(m_mask) : 32'd0);
      if (in_acc && m_write) checkOutput("data_bus", data_bus, m_wdata);
      checkOutput("responder_reg", resp_reg, exp_mem);
    end
    p_rst = rst; p_valid = req_valid; p_write = req_write; p_addr = req_addr;
    p_size = req_size; p_wdata = req_wdata; p_wait = nxt_wait; p_absent = nxt_absent;
    p_word = nxt_word; p_ready_exp = exp_ready;
  end

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                               input logic [31:0] wdata, input int unsigned wt, input logic absent,
                               input logic [31:0] word, input logic hold, output int acc);
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size; req_wdata = wdata;
    nxt_wait = wt; nxt_absent = absent; nxt_word = word;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    checks++;
    if (acc < 0) begin
      errors++;
      $display("[TB] FAIL accept_timeout: got no acceptance, expected acceptance within 50 cycles");
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic waitResp(input int acc, output int lat, output int strobes, output logic [3:0] mask_seen,
                          output logic saw_rd, output logic saw_wr);
    lat = -1; strobes = 0; mask_seen = 4'd0; saw_rd = 1'b0; saw_wr = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rd_bus || wr_bus) begin
        strobes++;
        mask_seen = data_mask_bus;
      end
      saw_rd = saw_rd | rd_bus;
      saw_wr = saw_wr | wr_bus;
      if (resp_valid) begin
        lat = cyc + 1 - acc;
        break;
      end
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("[TB] FAIL resp_timeout: got no resp_valid, expected one within 60 cycles");
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int acc, acc2, lat, lat2, strobes, rv;
    logic [3:0] mk;
    logic srd, swr;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_rdata", resp_rdata, 32'd0);
    checkOutput("reset_strobes", 32'({rd_bus, wr_bus}), 32'd0);
    checkOutput("reset_mask", 32'(data_mask_bus), 32'd0);

    // Zero-wait word write.
    applyStimulus(1'b1, 32'h8, 2'b10, 32'h0100_0001, 0, 1'b0, 32'd0, 1'b0, acc);
    waitResp(acc, lat, strobes, mk, srd, swr);
    checkOutput("wr_latency", 32'(lat), 32'd3);
    checkOutput("wr_error", 32'(resp_error), 32'd0);
    checkOutput("wr_mask", 32'(mk), 32'hF);
    checkOutput("wr_strobe_kind", 32'({srd, swr}), 32'b01);
    checkOutput("wr_responder_reg", resp_reg, 32'h0100_0001);

    // Zero-wait byte read.
    applyStimulus(1'b0, 32'h1, 2'b00, 32'd0, 0, 1'b0, 32'h0000_00AB, 1'b0, acc);
    waitResp(acc, lat, strobes, mk, srd, swr);
    checkOutput("rd_latency", 32'(lat), 32'd2);
    checkOutput("rd_rdata", resp_rdata, 32'h0000_00AB);
    checkOutput("rd_mask", 32'(mk), 32'h1);
    checkOutput("rd_strobe_kind", 32'({srd, swr}), 32'b10);

    // No responder: timeout after T access cycles.
    applyStimulus(1'b0, 32'h20, 2'b10, 32'd0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, acc);
    waitResp(acc, lat, strobes, mk, srd, swr);
    checkOutput("to_access_cycles", 32'(strobes), 32'd4);
    checkOutput("to_latency", 32'(lat), 32'd5);
    checkOutput("to_error", 32'(resp_error), 32'd1);
    checkOutput("to_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    checkOutput("to_ready_after", 32'(req_ready), 32'd1);

    // Misaligned half write is rejected without a bus cycle.
    applyStimulus(1'b1, 32'h3, 2'b01, 32'h1234, 0, 1'b0, 32'd0, 1'b0, acc);
    waitResp(acc, lat, strobes, mk, srd, swr);
    checkOutput("ill_latency", 32'(lat), 32'd1);
    checkOutput("ill_error", 32'(resp_error), 32'd1);
    checkOutput("ill_strobes", 32'(strobes), 32'd0);

    // Reset in the middle of a write access.
    applyStimulus(1'b1, 32'h40, 2'b10, 32'hCAFE_F00D, 0, 1'b1, 32'd0, 1'b0, acc);
    @(negedge clk);
    checkOutput("rst_pre_wr", 32'(wr_bus), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_wr_bus", 32'(wr_bus), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_addr_bus", addr_bus, 32'd0);
    rv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) rv++;
    end
    checkOutput("rst_no_resp", 32'(rv), 32'd0);

    // Back-to-back with req_valid held; request fields change mid-transfer.
    applyStimulus(1'b0, 32'h4, 2'b10, 32'd0, 1, 1'b0, 32'h5A5A_C3C3, 1'b1, acc);
    req_write = 1'b1; req_addr = 32'h22; req_size = 2'b01; req_wdata = 32'h0000_BEEF;
    nxt_wait = 0; nxt_absent = 1'b0;
    waitResp(acc, lat, strobes, mk, srd, swr);
    checkOutput("b2b_rd_latency", 32'(lat), 32'd3);
    checkOutput("b2b_rd_rdata", resp_rdata, 32'h5A5A_C3C3);
    applyStimulus(1'b1, 32'h22, 2'b01, 32'h0000_BEEF, 0, 1'b0, 32'd0, 1'b0, acc2);
    checkOutput("b2b_accept_gap", 32'(acc2 - acc), 32'(lat + 1));
    waitResp(acc2, lat2, strobes, mk, srd, swr);
    checkOutput("b2b_wr_latency", 32'(lat2), 32'd3);
    checkOutput("b2b_wr_mask", 32'(mk), 32'h3);
    checkOutput("b2b_responder_reg", resp_reg, 32'h0000_BEEF);

    // Random phase: requests, responder waits, absences and resets every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      rst        = ($urandom_range(0, 59) != 0);
      req_valid  = ($urandom_range(0, 2) != 0);
      req_write  = 1'($urandom_range(0, 1));
      req_size   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      req_addr   = $urandom;
      if ($urandom_range(0, 1) == 1) req_addr[1:0] = 2'b00;
      req_wdata  = $urandom;
      nxt_wait   = $urandom_range(0, 4);
      nxt_absent = ($urandom_range(0, 7) == 0);
      nxt_word   = $urandom;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum ACCESS cycles without fc_bus before the transfer aborts with error; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low; sampled on posedge clk.
REQ-004 req_valid  input  1  client requests a transfer.
REQ-005 req_write  input  1  1 = write, 0 = read.
REQ-006 req_addr  input  32  byte address, presented unmodified on addr_bus.
REQ-007 req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-008 req_wdata  input  32  write data, right-aligned in the low lanes.
REQ-009 req_ready  output  1  high only in IDLE; a transfer is accepted when req_valid && req_ready at posedge.
REQ-010 resp_valid  output  1  one-cycle pulse marking transfer completion.
REQ-011 resp_rdata  output  32  read data, right-aligned and zero-extended to size; 0 for writes and errors.
REQ-012 resp_error  output  1  qualified by resp_valid; 1 = timeout or illegal request.
REQ-013 addr_bus  output  32  bus address.
REQ-014 data_bus  inout  32  driven only during write ACCESS, otherwise high-Z.
REQ-015 rd_bus, wr_bus  output  1 each  registered strobes; never both high.
REQ-016 data_mask_bus  output  4  byte-lane enables: byte 0001, half 0011, word 1111.
REQ-017 fc_bus  input  1  responder completion; any value other than 1 counts as not complete.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE.
- One-hot or binary encoding is allowed.
- No other states.

REQ-019 IDLE behaviour.
- Bus outputs are 0 and data_bus is high-Z.
- On acceptance the block latches addr, size, write and wdata.
- It then enters ACCESS, or DONE with error when the request is illegal (REQ-020).

REQ-020 Illegal request: req_size = 11, or (req_addr[1:0] + bytes(size)) > 4.
- No bus cycle is issued.
- resp_error = 1.

REQ-021 ACCESS drives the bus from registers.
- addr_bus = latched address.
- data_mask_bus = mask for the latched size.
- rd_bus = !write, wr_bus = write.
- data_bus = wdata for writes.

REQ-022 ACCESS exit and counter.
- When fc_bus == 1 is sampled: a read captures data_bus masked to the size, then the FSM goes to DONE with error = 0.
- The cycle counter starts at 0 on entry and increments each ACCESS cycle without fc_bus.
- When the counter reaches TIMEOUT_CYCLES the FSM goes to DONE with error = 1 and rdata = 0.

REQ-023 DONE behaviour.
- rd_bus = wr_bus = 0, addr_bus = 0, data_mask_bus = 0, data_bus high-Z.
- resp_valid = 1 for exactly one cycle.
- The FSM returns to IDLE.
- This guarantees at least one idle bus cycle between transfers, so the responder can clear its write-complete flag.

REQ-024 Latency with a zero-wait responder.
- Read: acceptance edge to resp_valid = 2 cycles (fc_bus is combinational).
- Write: 3 cycles (fc_bus is registered one cycle after wr_bus).

REQ-025 Request inputs are ignored outside IDLE; changing them mid-transfer has no effect.

REQ-026 resp_rdata and resp_error hold their values until the next resp_valid.

Reset
REQ-027 rst low at posedge forces the following state, regardless of current state, including mid-ACCESS:
- FSM = IDLE, counter = 0.
- rd_bus = wr_bus = 0, addr_bus = 0, data_mask_bus = 0, data_bus high-Z.
- req_ready = 1 once rst is high.
- resp_valid = 0, resp_rdata = 0, resp_error = 0.

REQ-028 A transfer aborted by reset produces no resp_valid.

Verification
REQ-029 Word write: addr 0x8, data 0x01000001, size 10, zero-wait responder.
- Required: one ACCESS phase with wr_bus = 1, mask 1111.
- Required: resp_valid 3 cycles after acceptance, error 0.
- Required: responder data register = 0x01000001.

REQ-030 Byte read: addr 0x1, size 00, responder returns 0x000000AB with fc_bus = 1.
- Required: rd_bus = 1, mask 0001.
- Required: resp_valid 2 cycles after acceptance, rdata = 0x000000AB.

REQ-031 No responder (fc_bus = Z), TIMEOUT_CYCLES = 4.
- Required: ACCESS lasts exactly 4 cycles.
- Required: resp_error = 1, rdata = 0.
- Required: req_ready high the cycle after DONE.

REQ-032 Illegal half write at addr 0x3.
- Required: rd_bus and wr_bus never asserted.
- Required: resp_valid the cycle after acceptance with error = 1.

REQ-033 Reset pulled low during a write ACCESS.
- Required: at the next edge wr_bus = 0, data_bus high-Z, state IDLE.
- Required: no resp_valid is emitted.

REQ-034 Back-to-back requests with req_valid held high.
- Required: an idle DONE cycle between transfers.
- Required: rd_bus and wr_bus never overlap.
- Required: second transfer accepted on the first IDLE cycle.
